// File: rtl/if_stage_pkg.sv
// Shared fetch/decode definitions: opcode field, halt opcode, NOP encoding and fetch FSM states.
// Also imported by the decode-stage control decoder.
package if_stage_pkg;

   localparam logic [3:0]  OP_HLT     = 4'hF;
   localparam logic [15:0] NOP_INSTR  = 16'h0000;
   localparam int          PC_INC     = 2;
   localparam int          OPCODE_MSB = 15;
   localparam int          OPCODE_LSB = 12;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      DROP  = 2'd1,
      HOLD  = 2'd2,
      HALT  = 2'd3
   } fetchState_t;

   function automatic logic [3:0] opcodeOf(input logic [15:0] instr);
      return instr[OPCODE_MSB:OPCODE_LSB];
   endfunction

   function automatic logic isHalt(input logic [15:0] instr);
      return opcodeOf(instr) == OP_HLT;
   endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register with load, hold and flush; flush wins over everything else.
module if_id_reg
   import if_stage_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              flush,
   input  logic [15:0]       loadInstr,
   input  logic [ADDR_W-1:0] loadPc2,
   output logic [15:0]       instr,
   output logic [ADDR_W-1:0] pc2,
   output logic              valid
);

   // A flushed entry reads as a NOP so decode sees harmless opcode bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr <= NOP_INSTR;
         pc2   <= '0;
         valid <= 1'b0;
      end else if (flush) begin
         instr <= NOP_INSTR;
         pc2   <= '0;
         valid <= 1'b0;
      end else if (load) begin
         instr <= loadInstr;
         pc2   <= loadPc2;
         valid <= 1'b1;
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, variable-latency imem handshake, one-entry hold buffer and IF/ID register.
// Optional fetch stall counter is built only when IF_STALL_CNT_EN is defined.
module if_stage
   import if_stage_pkg::*;
#(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [15:0]       imem_rdata,
   input  logic              imem_valid,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   output logic [15:0]       ifid_instr,
   output logic [ADDR_W-1:0] ifid_pc2,
   output logic              ifid_valid,
   output logic              fetch_halted,
   output logic [15:0]       stall_cnt
);

   fetchState_t       state, stateNext;
   logic [ADDR_W-1:0] pc, pcNext;
   logic [ADDR_W-1:0] pcPlus2;
   logic [ADDR_W-1:0] dropAddr, dropAddrNext;
   logic [15:0]       holdInstr, holdInstrNext;
   logic [ADDR_W-1:0] holdPc2, holdPc2Next;
   logic              ifidLoad;
   logic              ifidFlush;
   logic [15:0]       ifidLoadInstr;
   logic [ADDR_W-1:0] ifidLoadPc2;

   assign pcPlus2 = pc + ADDR_W'(PC_INC);

   // DROP keeps presenting the abandoned address so the memory sees a stable request until it answers.
   assign imem_req     = (state == FETCH) || (state == DROP);
   assign imem_addr    = (state == DROP) ? dropAddr : pc;
   assign fetch_halted = (state == HALT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= FETCH;
         pc        <= RESET_PC;
         dropAddr  <= '0;
         holdInstr <= NOP_INSTR;
         holdPc2   <= '0;
      end else begin
         state     <= stateNext;
         pc        <= pcNext;
         dropAddr  <= dropAddrNext;
         holdInstr <= holdInstrNext;
         holdPc2   <= holdPc2Next;
      end
   end

   // Priority in every state: branch redirect, then memory response, then decode stall.
   always_comb begin
      stateNext     = state;
      pcNext        = pc;
      dropAddrNext  = dropAddr;
      holdInstrNext = holdInstr;
      holdPc2Next   = holdPc2;
      ifidLoad      = 1'b0;
      ifidLoadInstr = imem_rdata;
      ifidLoadPc2   = pcPlus2;

      case (state)
         FETCH: begin
            if (branch_taken) begin
               pcNext = branch_target;
               if (!imem_valid) begin
                  dropAddrNext = pc;
                  stateNext    = DROP;
               end
            end else if (imem_valid) begin
               pcNext = pcPlus2;
               if (stall) begin
                  holdInstrNext = imem_rdata;
                  holdPc2Next   = pcPlus2;
                  stateNext     = HOLD;
               end else begin
                  ifidLoad = 1'b1;
                  if (isHalt(imem_rdata)) begin
                     stateNext = HALT;
                  end
               end
            end
         end

         DROP: begin
            if (branch_taken) begin
               pcNext = branch_target;
            end
            if (imem_valid) begin
               stateNext = FETCH;
            end
         end

         HOLD: begin
            if (branch_taken) begin
               pcNext        = branch_target;
               holdInstrNext = NOP_INSTR;
               holdPc2Next   = '0;
               stateNext     = FETCH;
            end else if (!stall) begin
               ifidLoad      = 1'b1;
               ifidLoadInstr = holdInstr;
               ifidLoadPc2   = holdPc2;
               stateNext     = isHalt(holdInstr) ? HALT : FETCH;
            end
         end

         HALT: begin
            if (branch_taken) begin
               pcNext    = branch_target;
               stateNext = FETCH;
            end
         end

         default: begin
            stateNext = FETCH;
         end
      endcase

      // When decode consumes IF/ID and nothing new arrives, a bubble replaces the old word so it is not re-executed.
      ifidFlush = branch_taken | (~stall & ~ifidLoad);
   end

   if_id_reg #(
      .ADDR_W(ADDR_W)
   ) ifIdReg (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ifidLoad),
      .flush    (ifidFlush),
      .loadInstr(ifidLoadInstr),
      .loadPc2  (ifidLoadPc2),
      .instr    (ifid_instr),
      .pc2      (ifid_pc2),
      .valid    (ifid_valid)
   );

`ifdef IF_STALL_CNT_EN
   logic [15:0] stallCnt;

   // Counts cycles spent waiting on memory or parked in the hold buffer; sticks at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stallCnt <= 16'h0000;
      end else if (((imem_req & ~imem_valid) | (state == HOLD)) && (stallCnt != 16'hFFFF)) begin
         stallCnt <= stallCnt + 16'd1;
      end
   end

   assign stall_cnt = stallCnt;
`else
   assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: variable-latency memory, fetch model checked every cycle, directed scenarios.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata;
   logic        imem_valid;
   logic        stall;
   logic        branch_taken;
   logic [15:0] branch_target;
   logic [15:0] ifid_instr;
   logic [15:0] ifid_pc2;
   logic        ifid_valid;
   logic        fetch_halted;
   logic [15:0] stall_cnt;

   int checks = 0;
   int errors = 0;
   int waitStates = 0;
   int waitCnt;
   logic [15:0] mem [0:65535];

   typedef struct {
      logic [15:0] instr;
      logic [15:0] pc2;
   } word_t;

   logic [15:0] mPc;
   logic [15:0] mDropAddr;
   bit          mDropping;
   bit          mHalted;
   word_t       mBuf [$];
   logic [15:0] mIfInstr;
   logic [15:0] mIfPc2;
   bit          mIfValid;
   logic [15:0] mCnt;

   always #5 clk = ~clk;

   if_stage #(
      .ADDR_W  (16),
      .RESET_PC(16'h0000)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .imem_valid   (imem_valid),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .ifid_instr   (ifid_instr),
      .ifid_pc2     (ifid_pc2),
      .ifid_valid   (ifid_valid),
      .fetch_halted (fetch_halted),
      .stall_cnt    (stall_cnt)
   );

   // Memory answers after waitStates idle cycles of a continuous request.
   assign imem_valid = imem_req && (waitCnt >= waitStates);
   assign imem_rdata = imem_valid ? mem[imem_addr] : 16'hDEAD;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) waitCnt <= 0;
      else if (imem_req && !imem_valid) waitCnt <= waitCnt + 1;
      else waitCnt <= 0;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input bit br, input logic [15:0] tgt, input bit st);
      branch_taken  = br;
      branch_target = tgt;
      stall         = st;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Fetch model: a request is pending unless halted or a word is parked; a dropped request is ignored.
   function automatic bit expReq();
      return !mHalted && (mBuf.size() == 0);
   endfunction

   task automatic modelReset();
      mPc = 16'h0000;
      mDropAddr = 16'h0000;
      mDropping = 0;
      mHalted = 0;
      mBuf.delete();
      mIfInstr = 16'h0000;
      mIfPc2 = 16'h0000;
      mIfValid = 0;
      mCnt = 16'h0000;
   endtask

   task automatic modelIfid(input logic [15:0] instr, input logic [15:0] pc2, input bit vld);
      mIfInstr = instr;
      mIfPc2 = pc2;
      mIfValid = vld;
      if (vld && instr[15:12] == 4'hF) mHalted = 1;
   endtask

   task automatic modelStep();
      bit r;
      bit v;
      word_t w;
      r = expReq();
      v = r && (waitCnt >= waitStates);
      if (((r && !v) || mBuf.size() != 0) && mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
      if (branch_taken) begin
         if (mDropping) begin
            if (v) mDropping = 0;
         end else if (r && !v) begin
            mDropping = 1;
            mDropAddr = mPc;
         end
         mPc = branch_target;
         mBuf.delete();
         mHalted = 0;
         modelIfid(16'h0000, 16'h0000, 0);
      end else if (mDropping) begin
         if (v) mDropping = 0;
         if (!stall) modelIfid(16'h0000, 16'h0000, 0);
      end else if (r && v) begin
         w.instr = mem[mPc];
         w.pc2 = mPc + 16'd2;
         mPc = mPc + 16'd2;
         if (stall) mBuf.push_back(w);
         else modelIfid(w.instr, w.pc2, 1);
      end else if (mBuf.size() != 0 && !stall) begin
         w = mBuf.pop_front();
         modelIfid(w.instr, w.pc2, 1);
      end else if (!stall) begin
         modelIfid(16'h0000, 16'h0000, 0);
      end
   endtask

   task automatic compareAll();
      bit r;
      r = expReq();
      checkOutput("model.imem_req", imem_req, r);
      if (r) checkOutput("model.imem_addr", imem_addr, mDropping ? mDropAddr : mPc);
      checkOutput("model.ifid_instr", ifid_instr, mIfInstr);
      checkOutput("model.ifid_pc2", ifid_pc2, mIfPc2);
      checkOutput("model.ifid_valid", ifid_valid, mIfValid);
      checkOutput("model.fetch_halted", fetch_halted, mHalted);
`ifdef IF_STALL_CNT_EN
      checkOutput("model.stall_cnt", stall_cnt, mCnt);
`else
      checkOutput("model.stall_cnt", stall_cnt, 16'h0000);
`endif
   endtask

   // Compare at the falling edge, then advance the model with the inputs the next rising edge will see.
   always @(negedge clk) begin
      if (!rst_n) begin
         modelReset();
         compareAll();
      end else begin
         compareAll();
         modelStep();
      end
   end

   task automatic applyReset(input int ws);
      rst_n = 1'b0;
      applyStimulus(0, 16'h0000, 0);
      waitStates = ws;
      tick();
      checkOutput("rst.imem_req", imem_req, 1'b1);
      checkOutput("rst.imem_addr", imem_addr, 16'h0000);
      checkOutput("rst.ifid_valid", ifid_valid, 1'b0);
      checkOutput("rst.fetch_halted", fetch_halted, 1'b0);
      checkOutput("rst.stall_cnt", stall_cnt, 16'h0000);
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      bit found;
      logic [15:0] cntA;
      rst_n = 1'b0;
      applyStimulus(0, 16'h0000, 0);
      for (int a = 0; a < 65536; a++) mem[a] = {4'h7, 12'(a)};
      mem[16'h0000] = 16'h1123;
      mem[16'h0002] = 16'h2456;
      mem[16'h0004] = 16'hF000;
      mem[16'h0030] = 16'hF000;

      // Zero-wait straight-line program ending in HLT.
      applyReset(0);
      checkOutput("zw.addr0", imem_addr, 16'h0000);
      tick();
      checkOutput("zw.instr0", ifid_instr, 16'h1123);
      checkOutput("zw.pc2_0", ifid_pc2, 16'h0002);
      checkOutput("zw.valid0", ifid_valid, 1'b1);
      tick();
      checkOutput("zw.instr1", ifid_instr, 16'h2456);
      checkOutput("zw.pc2_1", ifid_pc2, 16'h0004);
      tick();
      checkOutput("zw.instr2", ifid_instr, 16'hF000);
      checkOutput("zw.pc2_2", ifid_pc2, 16'h0006);
      checkOutput("zw.halted", fetch_halted, 1'b1);
      checkOutput("zw.reqOff", imem_req, 1'b0);
      tick();
      checkOutput("zw.reqStillOff", imem_req, 1'b0);
      checkOutput("zw.haltedStill", fetch_halted, 1'b1);

      // Slow memory, response at 0x0010 lands while decode is stalled.
      applyReset(2);
      applyStimulus(1, 16'h0010, 0);
      tick();
      applyStimulus(0, 16'h0000, 1);
      found = 0;
      for (int i = 0; i < 20; i++) begin
         if (imem_req && imem_addr == 16'h0010 && imem_valid) begin
            found = 1;
            break;
         end
         tick();
      end
      checkOutput("lat.respAt10", found, 1'b1);
      tick();
      checkOutput("lat.holdReqOff", imem_req, 1'b0);
      checkOutput("lat.ifidUnchanged", ifid_valid, 1'b0);
      cntA = stall_cnt;
      tick();
`ifdef IF_STALL_CNT_EN
      checkOutput("lat.cntHold", stall_cnt, cntA + 16'd1);
`else
      checkOutput("lat.cntOff", stall_cnt, 16'h0000);
`endif
      applyStimulus(0, 16'h0000, 0);
      tick();
      checkOutput("lat.instr", ifid_instr, 16'h7010);
      checkOutput("lat.pc2", ifid_pc2, 16'h0012);
      checkOutput("lat.valid", ifid_valid, 1'b1);
      checkOutput("lat.nextAddr", imem_addr, 16'h0012);

      // Branch to 0x0040 while the request to 0x0008 is outstanding.
      applyReset(2);
      applyStimulus(1, 16'h0008, 0);
      tick();
      applyStimulus(0, 16'h0000, 0);
      found = 0;
      for (int i = 0; i < 20; i++) begin
         if (imem_req && imem_addr == 16'h0008 && !imem_valid) begin
            found = 1;
            break;
         end
         tick();
      end
      checkOutput("drop.reqAt8", found, 1'b1);
      applyStimulus(1, 16'h0040, 0);
      tick();
      applyStimulus(0, 16'h0000, 0);
      checkOutput("drop.flushValid", ifid_valid, 1'b0);
      found = 0;
      for (int i = 0; i < 20; i++) begin
         if (imem_valid) begin
            found = 1;
            break;
         end
         checkOutput("drop.addrHeld", imem_addr, 16'h0008);
         tick();
      end
      checkOutput("drop.respSeen", found, 1'b1);
      tick();
      checkOutput("drop.newAddr", imem_addr, 16'h0040);
      checkOutput("drop.newReq", imem_req, 1'b1);
      checkOutput("drop.ifidNop", ifid_instr, 16'h0000);
      checkOutput("drop.ifidInvalid", ifid_valid, 1'b0);

      // Branch and stall together: flush wins.
      applyReset(0);
      tick();
      tick();
      applyStimulus(1, 16'h0080, 1);
      tick();
      checkOutput("bs.valid", ifid_valid, 1'b0);
      checkOutput("bs.instr", ifid_instr, 16'h0000);
      checkOutput("bs.pc2", ifid_pc2, 16'h0000);
      checkOutput("bs.addr", imem_addr, 16'h0080);
      applyStimulus(0, 16'h0000, 1);
      tick();
      checkOutput("bs.holdReq", imem_req, 1'b0);
      applyStimulus(0, 16'h0000, 0);
      tick();
      checkOutput("bs.instrOut", ifid_instr, 16'h7080);
      checkOutput("bs.pc2Out", ifid_pc2, 16'h0082);

      // HLT reached through a branch, then resumed by another branch.
      applyReset(0);
      applyStimulus(1, 16'h0030, 0);
      tick();
      applyStimulus(0, 16'h0000, 0);
      tick();
      checkOutput("hlt.instr", ifid_instr, 16'hF000);
      checkOutput("hlt.halted", fetch_halted, 1'b1);
      tick();
      checkOutput("hlt.reqOff", imem_req, 1'b0);
      applyStimulus(1, 16'h0100, 0);
      tick();
      applyStimulus(0, 16'h0000, 0);
      checkOutput("hlt.resumed", fetch_halted, 1'b0);
      checkOutput("hlt.addr", imem_addr, 16'h0100);
      tick();
      checkOutput("hlt.instrAfter", ifid_instr, 16'h7100);
      checkOutput("hlt.pc2After", ifid_pc2, 16'h0102);

      // PC wrap at the top of the address space.
      applyReset(0);
      applyStimulus(1, 16'hFFFE, 0);
      tick();
      applyStimulus(0, 16'h0000, 0);
      checkOutput("wrap.addr", imem_addr, 16'hFFFE);
      tick();
      checkOutput("wrap.instr", ifid_instr, 16'h7FFE);
      checkOutput("wrap.pc2", ifid_pc2, 16'h0000);
      checkOutput("wrap.nextAddr", imem_addr, 16'h0000);

      // Asynchronous reset in the middle of a dropped request.
      applyReset(2);
      applyStimulus(1, 16'h0050, 0);
      tick();
      applyStimulus(0, 16'h0000, 0);
      checkOutput("ar.dropAddr", imem_addr, 16'h0000);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("ar.req", imem_req, 1'b1);
      checkOutput("ar.addr", imem_addr, 16'h0000);
      checkOutput("ar.instr", ifid_instr, 16'h0000);
      checkOutput("ar.valid", ifid_valid, 1'b0);
      checkOutput("ar.halted", fetch_halted, 1'b0);
      checkOutput("ar.cnt", stall_cnt, 16'h0000);
      tick();
      rst_n = 1'b1;
      repeat (8) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
